instruction_fetch_controller: RTL

Sequences the combinational, word-addressed instruction memory. Holds the program counter and drives the memory address. Captures each returned word into a one-entry output register and presents it to decode under a valid/ready handshake. Handles start, halt, branch redirect and out-of-range fault, and sits between the instruction memory and the decode stage of the CPU datapath.

---
 rtl/instruction_fetch_controller.sv | 111 +++++++++++
 1 files changed

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads the combinational instruction memory and
// holds a one-entry output register that decode drains through a valid/ready handshake.
module instruction_fetch_controller #(
  parameter int unsigned MEM_DEPTH = 100,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        running,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] DepthW = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StHalted, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic xfer;
  logic slot_free;
  logic pc_in_range;

  assign xfer        = if_valid_q && id_ready;
  assign slot_free   = !if_valid_q || id_ready;
  assign pc_in_range = pc_q < DepthW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'd0;
      if_pc_q       <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    fetch_count_d = fetch_count_q;

    // A flushed entry (br_valid) is never counted even if decode was ready.
    if (xfer && !br_valid) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if (xfer) begin
      if_valid_d = 1'b0;
    end

    if (state_q == StFault) begin
      // Locked until reset; the entry register is already empty here.
    end else if (br_valid) begin
      pc_d       = br_target;
      if_valid_d = 1'b0;
    end else if (halt_req) begin
      if (state_q == StRun) begin
        state_d = StHalted;
      end
    end else if (start && (state_q != StRun)) begin
      state_d = StRun;
    end else if ((state_q == StRun) && slot_free) begin
      if (pc_in_range) begin
        if_instr_d = imem_instr;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
        pc_d       = pc_q + 32'd1;
      end else begin
        state_d    = StFault;
        if_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    imem_addr   = pc_q;
    if_valid    = if_valid_q;
    if_instr    = if_instr_q;
    if_pc       = if_pc_q;
    running     = (state_q == StRun);
    fault       = (state_q == StFault);
    fetch_count = fetch_count_q;
  end

endmodule
